// File: rtl/keypad_lock_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_lock_ctrl
//   Passcode lock controller for the PmodKYPD keypad path. Debounces the raw
//   decoder output, emits one strobe per accepted press, checks a CODE_LEN
//   digit sequence, locks out after MAX_FAILS failed attempts and abandons
//   entries that go stale. Produces a 4-bit code for the display driver.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   key_down   in   raw "any key pressed" from the decoder
//   key_code   in   raw decoded key value (meaningful while key_down=1)
//   relock     in   one-cycle request to leave OPEN
//   key_stb    out  one-cycle pulse per accepted press
//   key_last   out  code of the most recent accepted press
//   digit_cnt  out  digits entered in the current attempt
//   fail_cnt   out  consecutive failed attempts
//   unlocked   out  1 while OPEN
//   lockout    out  1 while LOCKOUT
//   disp_state out  digit_cnt in IDLE/ENTRY, 4'hF in OPEN, 4'hE in LOCKOUT
// ---------------------------------------------------------------------------
module keypad_lock_ctrl #(
  parameter int          CODE_LEN        = 4,
  parameter logic [31:0] CODE            = 32'h000071B8,
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter int          TIMEOUT_CYCLES  = 500_000_000,
  parameter int          MAX_FAILS       = 3,
  parameter int          LOCKOUT_CYCLES  = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_down,
  input  logic [3:0] key_code,
  input  logic       relock,
  output logic       key_stb,
  output logic [3:0] key_last,
  output logic [3:0] digit_cnt,
  output logic [3:0] fail_cnt,
  output logic       unlocked,
  output logic       lockout,
  output logic [3:0] disp_state
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LO_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LO_W-1:0] LO_LOAD = LO_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]      LEN     = 4'(CODE_LEN);
  localparam logic [3:0]      MAXF    = 4'(MAX_FAILS);

  // -------------------------------------------------------------------------
  // Debouncer
  // -------------------------------------------------------------------------
  logic [4:0]      sample_reg;   // {key_down, key_code} registered once
  logic [DB_W-1:0] stable_cnt;   // cycles the sample has been unchanged
  logic            armed_reg;    // a press may be accepted

  // The counter saturates at DB_MAX so the "stable" condition persists; the
  // armed flag guarantees one strobe per press. Reset leaves the debouncer
  // disarmed so a key held through reset must be released before it counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_reg <= '0;
      stable_cnt <= '0;
      armed_reg  <= 1'b0;
      key_stb    <= 1'b0;
      key_last   <= 4'h0;
    end else begin
      sample_reg <= {key_down, key_code};
      key_stb    <= 1'b0;
      if ({key_down, key_code} != sample_reg) begin
        stable_cnt <= '0;
      end else if (stable_cnt != DB_MAX) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
      if (stable_cnt == DB_MAX) begin
        if (sample_reg[4] && armed_reg) begin
          key_stb   <= 1'b1;
          key_last  <= sample_reg[3:0];
          armed_reg <= 1'b0;
        end else if (!sample_reg[4]) begin
          armed_reg <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lock FSM
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  state_t          state_reg;
  logic            mismatch_reg;  // sticky: some digit of this attempt was wrong
  logic [TO_W-1:0] tmo_cnt;
  logic [LO_W-1:0] lock_cnt;

  logic [3:0] exp_digit;
  logic [3:0] digit_inc;
  logic [3:0] fail_inc;
  logic       mismatch_next;
  logic       eval_now;

  // Expected digit for the position about to be entered; the first digit
  // lives in the most significant used nibble of CODE.
  always_comb begin
    exp_digit = 4'h0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_cnt == 4'(i)) begin
        exp_digit = 4'(CODE >> (4 * (CODE_LEN - 1 - i)));
      end
    end
  end

  assign digit_inc     = digit_cnt + 4'd1;
  assign fail_inc      = fail_cnt + 4'd1;
  assign mismatch_next = mismatch_reg | (key_last != exp_digit);
  assign eval_now      = (digit_inc == LEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      mismatch_reg <= 1'b0;
      tmo_cnt      <= '0;
      lock_cnt     <= '0;
      digit_cnt    <= 4'h0;
      fail_cnt     <= 4'h0;
      unlocked     <= 1'b0;
      lockout      <= 1'b0;
      disp_state   <= 4'h0;
    end else begin
      case (state_reg)
        // IDLE and ENTRY share the digit path so CODE_LEN=1 evaluates
        // straight from IDLE.
        S_IDLE, S_ENTRY: begin
          if (key_stb) begin
            tmo_cnt <= '0;
            if (eval_now) begin
              digit_cnt    <= 4'h0;
              mismatch_reg <= 1'b0;
              if (!mismatch_next) begin
                state_reg  <= S_OPEN;
                fail_cnt   <= 4'h0;
                unlocked   <= 1'b1;
                disp_state <= 4'hF;
              end else if (fail_inc < MAXF) begin
                state_reg  <= S_IDLE;
                fail_cnt   <= fail_inc;
                disp_state <= 4'h0;
              end else begin
                state_reg  <= S_LOCKOUT;
                fail_cnt   <= MAXF;
                lockout    <= 1'b1;
                disp_state <= 4'hE;
                lock_cnt   <= LO_LOAD;
              end
            end else begin
              state_reg    <= S_ENTRY;
              digit_cnt    <= digit_inc;
              mismatch_reg <= mismatch_next;
              disp_state   <= digit_inc;
            end
          end else if (state_reg == S_ENTRY) begin
            // Stale entry: abandon silently, not counted as a failure.
            if (tmo_cnt == TO_LAST) begin
              state_reg    <= S_IDLE;
              digit_cnt    <= 4'h0;
              mismatch_reg <= 1'b0;
              disp_state   <= 4'h0;
              tmo_cnt      <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end

        // Keys are ignored here; a relock that coincides with a key strobe
        // still returns to IDLE and the key is simply dropped.
        S_OPEN: begin
          if (relock) begin
            state_reg  <= S_IDLE;
            unlocked   <= 1'b0;
            digit_cnt  <= 4'h0;
            disp_state <= 4'h0;
          end
        end

        S_LOCKOUT: begin
          if (lock_cnt == '0) begin
            state_reg  <= S_IDLE;
            lockout    <= 1'b0;
            fail_cnt   <= 4'h0;
            disp_state <= 4'h0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_lock_ctrl
//   Self-checking bench for keypad_lock_ctrl with short timing parameters.
//   The reference model keeps the entered digits in a queue, a failure count,
//   open/lockout flags and timestamps, and predicts the outputs after every
//   accepted key strobe.
// ---------------------------------------------------------------------------
module tb_keypad_lock_ctrl;

  localparam int          CL     = 4;
  localparam int          D      = 4;
  localparam int          T      = 50;
  localparam int          L      = 100;
  localparam int          MF     = 3;
  localparam logic [31:0] CODE_P = 32'h000071B8;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       key_down = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       relock   = 1'b0;
  logic       key_stb;
  logic [3:0] key_last;
  logic [3:0] digit_cnt;
  logic [3:0] fail_cnt;
  logic       unlocked;
  logic       lockout;
  logic [3:0] disp_state;

  keypad_lock_ctrl #(
    .CODE_LEN       (CL),
    .CODE           (CODE_P),
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T),
    .MAX_FAILS      (MF),
    .LOCKOUT_CYCLES (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_down  (key_down),
    .key_code  (key_code),
    .relock    (relock),
    .key_stb   (key_stb),
    .key_last  (key_last),
    .digit_cnt (digit_cnt),
    .fail_cnt  (fail_cnt),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .disp_state(disp_state)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  wire [13:0] dut_outputs = {digit_cnt, fail_cnt, unlocked, lockout, disp_state};

  // ---------------- reference model ----------------
  int m_digits[$];
  int m_fails      = 0;
  bit m_open       = 1'b0;
  bit m_lock       = 1'b0;
  int m_lock_start = 0;
  int m_last_time  = 0;

  function automatic logic [3:0] code_digit(input int i);
    logic [31:0] c;
    c = CODE_P >> (4 * (CL - 1 - i));
    return c[3:0];
  endfunction

  function automatic void model_reset();
    m_digits.delete();
    m_fails = 0;
    m_open  = 1'b0;
    m_lock  = 1'b0;
  endfunction

  // Apply elapsed-time rules; callers only ask well clear of the boundaries.
  function automatic void model_advance(input int now);
    if (m_lock && (now - m_lock_start > L + 5)) begin
      m_lock  = 1'b0;
      m_fails = 0;
    end
    if (m_digits.size() > 0 && (now - m_last_time > T + 5)) m_digits.delete();
  endfunction

  function automatic void model_key(input logic [3:0] k, input int now);
    bit ok;
    model_advance(now);
    if (m_lock || m_open) return;
    m_digits.push_back(int'(k));
    m_last_time = now;
    if (m_digits.size() == CL) begin
      ok = 1'b1;
      for (int i = 0; i < CL; i++) if (m_digits[i] != int'(code_digit(i))) ok = 1'b0;
      m_digits.delete();
      if (ok) begin
        m_open  = 1'b1;
        m_fails = 0;
      end else begin
        m_fails++;
        if (m_fails >= MF) begin
          m_lock       = 1'b1;
          m_lock_start = now;
        end
      end
    end
  endfunction

  function automatic logic [13:0] model_outputs();
    logic [3:0] disp;
    disp = m_lock ? 4'hE : (m_open ? 4'hF : 4'(m_digits.size()));
    return {4'(m_digits.size()), 4'(m_fails), m_open, m_lock, disp};
  endfunction

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    key_down = 1'b0;
    relock   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Hold a key, release it, and check every strobe plus the outputs on the
  // cycle after each strobe.
  task automatic press(input logic [3:0] code, input int hold, input int rel,
                       input int exp_stb, input string tag);
    int nstb;
    bit pend;
    int i;
    nstb = 0;
    pend = 1'b0;
    i    = 0;
    while (i < hold + rel || pend) begin
      key_code = code;
      key_down = (i < hold);
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        checks++;
        if (dut_outputs !== model_outputs())
          begin errors++; $display("FAIL %s post_stb: got %h want %h", tag, dut_outputs, model_outputs()); end
      end
      if (key_stb === 1'b1) begin
        nstb++;
        checks++;
        if (key_last !== code)
          begin errors++; $display("FAIL %s key_last: got %h want %h", tag, key_last, code); end
        model_key(code, cycle);
        pend = 1'b1;
      end
      i++;
    end
    checks++;
    if (nstb != exp_stb)
      begin errors++; $display("FAIL %s stb_count: got %0d want %0d", tag, nstb, exp_stb); end
    $display("press %s key=%h hold=%0d rel=%0d strobes=%0d", tag, code, hold, rel, nstb);
  endtask

  task automatic test_reset();
    int nstb;
    nstb     = 0;
    rst      = 1'b1;
    key_down = 1'b1;
    key_code = 4'h5;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_stb, key_last, dut_outputs} !== 19'h0)
      begin errors++; $display("FAIL reset_state: got %h want 0", {key_stb, key_last, dut_outputs}); end
    rst = 1'b0;
    model_reset();
    repeat (20) begin
      @(negedge clk);
      if (key_stb === 1'b1) nstb++;
    end
    checks++;
    if (nstb != 0)
      begin errors++; $display("FAIL held_through_reset: got %0d strobes want 0", nstb); end
    idle(10);
    $display("test_reset done");
  endtask

  task automatic test_unlock();
    press(4'h7, 10, 10, 1, "unlock");
    press(4'h1, 10, 10, 1, "unlock");
    press(4'hB, 10, 10, 1, "unlock");
    press(4'h8, 10, 10, 1, "unlock");
    checks++;
    if (unlocked !== 1'b1 || disp_state !== 4'hF || fail_cnt !== 4'h0)
      begin errors++; $display("FAIL unlock_open: got u=%b d=%h f=%h want u=1 d=F f=0", unlocked, disp_state, fail_cnt); end
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    m_open = 1'b0;
    checks++;
    if (dut_outputs !== model_outputs() || unlocked !== 1'b0)
      begin errors++; $display("FAIL relock: got %h want %h", dut_outputs, model_outputs()); end
    $display("test_unlock done");
  endtask

  task automatic test_bounce();
    int nstb;
    logic [3:0] k;
    nstb = 0;
    k    = 4'($urandom_range(0, 15));
    for (int i = 0; i < 40; i++) begin
      key_code = k;
      key_down = (i < 20) ? ((i / 2) % 2 == 0) : (i < 30);
      @(negedge clk);
      if (key_stb === 1'b1) begin
        nstb++;
        model_key(k, cycle);
        checks++;
        if (key_last !== k)
          begin errors++; $display("FAIL bounce_key_last: got %h want %h", key_last, k); end
      end
    end
    checks++;
    if (nstb != 1) begin errors++; $display("FAIL bounce_count: got %0d want 1", nstb); end
    checks++;
    if (dut_outputs !== model_outputs())
      begin errors++; $display("FAIL bounce_state: got %h want %h", dut_outputs, model_outputs()); end
    $display("test_bounce key=%h strobes=%0d", k, nstb);
  endtask

  task automatic test_code_change();
    int nstb;
    nstb = 0;
    for (int i = 0; i < 22; i++) begin
      key_code = (i < 2) ? 4'h7 : 4'h1;
      key_down = (i < 12);
      @(negedge clk);
      if (key_stb === 1'b1) begin
        nstb++;
        model_key(4'h1, cycle);
        checks++;
        if (key_last !== 4'h1)
          begin errors++; $display("FAIL code_change_key: got %h want 1", key_last); end
      end
    end
    checks++;
    if (nstb != 1) begin errors++; $display("FAIL code_change_count: got %0d want 1", nstb); end
    $display("test_code_change strobes=%0d", nstb);
  endtask

  task automatic test_timeout();
    idle(70);
    model_advance(cycle);
    checks++;
    if (dut_outputs !== model_outputs() || digit_cnt !== 4'h0)
      begin errors++; $display("FAIL timeout_prior: got %h want %h", dut_outputs, model_outputs()); end
    for (int i = 0; i < CL; i++) press(4'h0, 10, 10, 1, "fail_once");
    press(4'h7, 10, 10, 1, "partial");
    press(4'h1, 10, 10, 1, "partial");
    idle(70);
    model_advance(cycle);
    checks++;
    if (digit_cnt !== 4'h0 || fail_cnt !== 4'h1 || dut_outputs !== model_outputs())
      begin errors++; $display("FAIL timeout_abort: got %h want %h", dut_outputs, model_outputs()); end
    press(4'h7, 10, 10, 1, "after_tmo");
    press(4'h1, 10, 10, 1, "after_tmo");
    press(4'hB, 10, 10, 1, "after_tmo");
    press(4'h8, 10, 10, 1, "after_tmo");
    checks++;
    if (unlocked !== 1'b1 || fail_cnt !== 4'h0)
      begin errors++; $display("FAIL timeout_unlock: got u=%b f=%h want u=1 f=0", unlocked, fail_cnt); end
    $display("test_timeout done");
  endtask

  // Assumes OPEN on entry.
  task automatic test_relock_with_key();
    int nstb;
    bit pend;
    nstb = 0;
    pend = 1'b0;
    for (int i = 0; i < 20; i++) begin
      key_code = 4'h5;
      key_down = (i < 10);
      @(negedge clk);
      if (pend) begin
        pend   = 1'b0;
        relock = 1'b0;
        checks++;
        if (dut_outputs !== model_outputs() || digit_cnt !== 4'h0 || unlocked !== 1'b0)
          begin errors++; $display("FAIL relock_with_key: got %h want %h", dut_outputs, model_outputs()); end
      end
      if (key_stb === 1'b1) begin
        nstb++;
        model_key(4'h5, cycle);
        m_open = 1'b0;
        relock = 1'b1;
        pend   = 1'b1;
      end
    end
    relock = 1'b0;
    checks++;
    if (nstb != 1) begin errors++; $display("FAIL relock_key_count: got %0d want 1", nstb); end
    press(4'h7, 10, 10, 1, "after_relock");
    idle(70);
    model_advance(cycle);
    $display("test_relock_with_key done");
  endtask

  task automatic test_fail_lockout();
    logic [3:0] seq [4];
    seq[0] = 4'h7; seq[1] = 4'h1; seq[2] = 4'hB; seq[3] = 4'h9;
    for (int a = 0; a < 3; a++) begin
      for (int d = 0; d < 4; d++) press(seq[d], 10, 10, 1, "wrong");
      checks++;
      if (fail_cnt !== 4'(a + 1) || lockout !== (a == 2) || disp_state !== ((a == 2) ? 4'hE : 4'h0))
        begin errors++; $display("FAIL attempt_%0d: got f=%h l=%b d=%h", a, fail_cnt, lockout, disp_state); end
    end
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    checks++;
    if (lockout !== 1'b1) begin errors++; $display("FAIL relock_in_lockout: got %b want 1", lockout); end
    press(4'h7, 8, 8, 1, "in_lock");
    press(4'h1, 8, 8, 1, "in_lock");
    press(4'hB, 8, 8, 1, "in_lock");
    press(4'h8, 8, 8, 1, "in_lock");
    while (cycle < m_lock_start + L - 10) @(negedge clk);
    checks++;
    if (lockout !== 1'b1 || unlocked !== 1'b0)
      begin errors++; $display("FAIL lock_held: got l=%b u=%b want l=1 u=0", lockout, unlocked); end
    while (cycle < m_lock_start + L + 10) @(negedge clk);
    model_advance(cycle);
    checks++;
    if (lockout !== 1'b0 || fail_cnt !== 4'h0 || dut_outputs !== model_outputs())
      begin errors++; $display("FAIL lock_exit: got %h want %h", dut_outputs, model_outputs()); end
    $display("test_fail_lockout done");
  endtask

  task automatic test_random();
    logic [3:0] k;
    for (int a = 0; a < 8; a++) begin
      for (int d = 0; d < CL; d++) begin
        if ($urandom_range(0, 3) == 0)
          press(4'($urandom_range(0, 15)), $urandom_range(1, 2), 8, 0, "glitch");
        k = ($urandom_range(0, 1) == 1) ? code_digit(d) : 4'($urandom_range(0, 15));
        press(k, $urandom_range(8, 12), $urandom_range(8, 12), 1, "random");
      end
      if (m_open) begin
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        m_open = 1'b0;
        checks++;
        if (dut_outputs !== model_outputs())
          begin errors++; $display("FAIL random_relock: got %h want %h", dut_outputs, model_outputs()); end
      end
      if (m_lock) begin
        while (cycle < m_lock_start + L + 10) @(negedge clk);
        model_advance(cycle);
        checks++;
        if (dut_outputs !== model_outputs())
          begin errors++; $display("FAIL random_lock_exit: got %h want %h", dut_outputs, model_outputs()); end
      end
      $display("random attempt %0d fails=%0d", a, m_fails);
    end
  endtask

  task automatic test_reset_in_lockout();
    int guard;
    guard = 0;
    while (!m_lock && guard < 20) begin
      press(4'h2, 10, 10, 1, "to_lock");
      guard++;
    end
    checks++;
    if (lockout !== 1'b1) begin errors++; $display("FAIL reach_lockout: got %b want 1", lockout); end
    idle(20);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({key_stb, key_last, dut_outputs} !== 19'h0)
      begin errors++; $display("FAIL reset_in_lockout: got %h want 0", {key_stb, key_last, dut_outputs}); end
    rst = 1'b0;
    model_reset();
    idle(10);
    press(4'h7, 10, 10, 1, "post_reset");
    $display("test_reset_in_lockout done");
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_bounce();
    test_code_change();
    test_timeout();
    test_relock_with_key();
    test_fail_lockout();
    test_random();
    test_reset_in_lockout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
